// File: rtl/code_entry_ctrl.sv
`default_nettype none
// ============================================================================
// code_entry_ctrl - MasterMind player code entry: cursor, wrap-around symbol
// edits, duplicate check and valid/ready hand-off to the game core.
// Revision: 1.0
// ============================================================================
module code_entry_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SYMBOLS   = 6,
  parameter int ALLOW_DUP = 0,
  localparam int VAL_W    = (SYMBOLS > 2) ? $clog2(SYMBOLS) : 1,
  localparam int CUR_W    = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_next,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_submit,
  input  logic                          clear,
  input  logic                          submit_ready,
  output logic [DIGITS*VAL_W-1:0]       code,
  output logic [CUR_W-1:0]              cursor,
  output logic [DIGITS*(VAL_W+1)-1:0]   disp,
  output logic                          submit_valid,
  output logic                          dup_err,
  output logic                          locked
);

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_SUBMIT = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [DIGITS*VAL_W-1:0]    code_d;
  logic [CUR_W-1:0]           cursor_d;
  logic                       dup_d;
  logic                       has_dup;
  logic [VAL_W-1:0]           cur_val;
  logic [VAL_W-1:0]           edit_val;

  always_comb begin
    has_dup = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = i + 1; j < DIGITS; j++) begin
        if (code[i*VAL_W +: VAL_W] == code[j*VAL_W +: VAL_W]) begin
          has_dup = 1'b1;
        end
      end
    end
  end

  // Value under the cursor and its edited form; compare-wrap keeps
  // non-power-of-2 symbol counts in range.
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cursor == CUR_W'(i)) begin
        cur_val = code[i*VAL_W +: VAL_W];
      end
    end
    edit_val = cur_val;
    if (btn_inc && !btn_dec) begin
      edit_val = (cur_val == VAL_W'(SYMBOLS - 1)) ? '0 : cur_val + VAL_W'(1);
    end else if (btn_dec && !btn_inc) begin
      edit_val = (cur_val == '0) ? VAL_W'(SYMBOLS - 1) : cur_val - VAL_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code;
    cursor_d = cursor;
    dup_d    = 1'b0;
    if (clear) begin
      state_d  = ST_EDIT;
      code_d   = '0;
      cursor_d = '0;
    end else begin
      case (state_q)
        ST_EDIT: begin
          if (btn_submit) begin
            if ((ALLOW_DUP == 0) && has_dup) begin
              dup_d = 1'b1;
            end else begin
              state_d = ST_SUBMIT;
            end
          end else begin
            // Edit lands on the old cursor position even when NEXT is also pressed.
            for (int i = 0; i < DIGITS; i++) begin
              if (cursor == CUR_W'(i)) begin
                code_d[i*VAL_W +: VAL_W] = edit_val;
              end
            end
            if (btn_next) begin
              cursor_d = (cursor == CUR_W'(DIGITS - 1)) ? '0 : cursor + CUR_W'(1);
            end
          end
        end
        ST_SUBMIT: begin
          if (submit_ready) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: begin
          state_d = ST_EDIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EDIT;
      code    <= '0;
      cursor  <= '0;
      dup_err <= 1'b0;
    end else begin
      state_q <= state_d;
      code    <= code_d;
      cursor  <= cursor_d;
      dup_err <= dup_d;
    end
  end

  // Decoded straight from the state register so an async reset drops VALID at once.
  assign submit_valid = (state_q == ST_SUBMIT);
  assign locked       = (state_q == ST_LOCKED);

  for (genvar g = 0; g < DIGITS; g++) begin : g_disp
    assign disp[g*(VAL_W+1) +: VAL_W+1] =
      {(state_q == ST_EDIT) && (cursor == CUR_W'(g)), code[g*VAL_W +: VAL_W]};
  end

endmodule
`default_nettype wire

// File: tb/tb_code_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_code_entry_ctrl - two configurations (4x6 no-dup, 5x8 dup allowed) driven
// in lockstep and compared every cycle against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_code_entry_ctrl;

  logic clk = 1'b0;
  logic rst_n, btn_next, btn_inc, btn_dec, btn_submit, clear, submit_ready;

  logic [11:0] code0;
  logic [1:0]  cur0;
  logic [15:0] disp0;
  logic        valid0, dup0, locked0;
  logic [14:0] code1;
  logic [2:0]  cur1;
  logic [19:0] disp1;
  logic        valid1, dup1, locked1;

  int errors = 0;
  int checks = 0;

  int m_code  [2][8];
  int m_cur   [2];
  bit m_valid [2];
  bit m_locked[2];
  bit m_dup   [2];

  always #5 clk = ~clk;

  code_entry_ctrl #(.DIGITS(4), .SYMBOLS(6), .ALLOW_DUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_submit(btn_submit), .clear(clear),
    .submit_ready(submit_ready), .code(code0), .cursor(cur0), .disp(disp0),
    .submit_valid(valid0), .dup_err(dup0), .locked(locked0)
  );

  code_entry_ctrl #(.DIGITS(5), .SYMBOLS(8), .ALLOW_DUP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_submit(btn_submit), .clear(clear),
    .submit_ready(submit_ready), .code(code1), .cursor(cur1), .disp(disp1),
    .submit_valid(valid1), .dup_err(dup1), .locked(locked1)
  );

  function automatic int n_dig(int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int n_sym(int k);
    return (k == 0) ? 6 : 8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_code[k][i] = 0;
      m_cur[k] = 0; m_valid[k] = 0; m_locked[k] = 0; m_dup[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int seen[8];
      bit dups;
      m_dup[k] = 0;
      if (clear) begin
        for (int i = 0; i < 8; i++) m_code[k][i] = 0;
        m_cur[k] = 0; m_valid[k] = 0; m_locked[k] = 0;
      end else if (m_locked[k]) begin
        // nothing moves until CLEAR
      end else if (m_valid[k]) begin
        if (submit_ready) begin
          m_valid[k] = 0; m_locked[k] = 1;
        end
      end else if (btn_submit) begin
        dups = 0;
        for (int s = 0; s < 8; s++) seen[s] = 0;
        for (int i = 0; i < n_dig(k); i++) seen[m_code[k][i]]++;
        for (int s = 0; s < 8; s++) if (seen[s] > 1) dups = 1;
        if (dups && k == 0) m_dup[k] = 1;
        else m_valid[k] = 1;
      end else begin
        if (btn_inc && !btn_dec)
          m_code[k][m_cur[k]] = (m_code[k][m_cur[k]] + 1) % n_sym(k);
        if (btn_dec && !btn_inc)
          m_code[k][m_cur[k]] = (m_code[k][m_cur[k]] + n_sym(k) - 1) % n_sym(k);
        if (btn_next) m_cur[k] = (m_cur[k] + 1) % n_dig(k);
      end
    end
  endtask

  task automatic check(string tag, int k, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] ec, ed;
      bit edit;
      ec = '0; ed = '0;
      edit = !m_valid[k] && !m_locked[k];
      for (int i = 0; i < n_dig(k); i++) begin
        ec = ec | (64'(m_code[k][i]) << (3 * i));
        ed = ed | ((64'(m_code[k][i]) | ((edit && m_cur[k] == i) ? 64'd8 : 64'd0)) << (4 * i));
      end
      check("code",   k, (k == 0) ? 64'(code0)   : 64'(code1),   ec);
      check("cursor", k, (k == 0) ? 64'(cur0)    : 64'(cur1),    64'(m_cur[k]));
      check("disp",   k, (k == 0) ? 64'(disp0)   : 64'(disp1),   ed);
      check("valid",  k, (k == 0) ? 64'(valid0)  : 64'(valid1),  64'(m_valid[k]));
      check("duperr", k, (k == 0) ? 64'(dup0)    : 64'(dup1),    64'(m_dup[k]));
      check("locked", k, (k == 0) ? 64'(locked0) : 64'(locked1), 64'(m_locked[k]));
    end
  endtask

  task automatic step(bit nx, bit inc, bit dec, bit sub, bit clr, bit rdy);
    btn_next = nx; btn_inc = inc; btn_dec = dec;
    btn_submit = sub; clear = clr; submit_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    btn_next = 0; btn_inc = 0; btn_dec = 0; btn_submit = 0; clear = 0;
  endtask

  initial begin
    rst_n = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
    btn_submit = 0; clear = 0; submit_ready = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1;

    // wrap of symbol values in both directions, cursor at digit 0
    repeat (7) step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    // cursor wrap, then NEXT+INC edits the old position
    repeat (5) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // code {0,0,1,2}: rejected by the no-dup config, accepted by the other
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // code {3,2,1,0}, held offer while READY low and buttons pressed
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // locked ignores buttons; CLEAR wins over a same-cycle INC
    step(0, 1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);

    // all-equal code offered by the dup-allowed config, then async reset
    step(0, 0, 0, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst_n = 1;

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
